// File: rtl/packet_reader_pkg.sv
// ---------------------------------------------------------------------------
// packet_reader_pkg
// Shared definitions for the concentrator packet RAM read side (and the
// write side): default widths, reader FSM state encoding, and the RAM
// address builder {slot, byte_idx}.
// ---------------------------------------------------------------------------
package packet_reader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SENS_LOG_DEF   = 3;
  localparam int PKT_LOG_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // Packet RAM address: slot index in the upper bits, byte index in the low
  // pkt_log bits. The caller truncates the result to its address width.
  function automatic logic [31:0] slot_addr(input logic [15:0]  slot,
                                            input logic [15:0]  byte_idx,
                                            input int unsigned  pkt_log);
    logic [31:0] mask;
    mask = (32'd1 << pkt_log) - 32'd1;
    return ({16'd0, slot} << pkt_log) | ({16'd0, byte_idx} & mask);
  endfunction

endpackage

// File: rtl/packet_reader_rr_arbiter.sv
// ---------------------------------------------------------------------------
// packet_reader_rr_arbiter
// Combinational round-robin search: returns the first set bit of slot_full
// starting at rr_ptr and wrapping modulo the slot count.
// Ports:
//   slot_full  in  one bit per slot, 1 = slot requests service
//   rr_ptr     in  index searched first
//   found      out at least one request is set
//   index      out index of the winning slot (0 when found=0)
// ---------------------------------------------------------------------------
module packet_reader_rr_arbiter
  import packet_reader_pkg::*;
#(
  parameter int SENS_LOG = SENS_LOG_DEF
) (
  input  logic [(1<<SENS_LOG)-1:0] slot_full,
  input  logic [SENS_LOG-1:0]      rr_ptr,
  output logic                     found,
  output logic [SENS_LOG-1:0]      index
);

  localparam int NUM_SLOTS = 1 << SENS_LOG;

  logic [SENS_LOG-1:0] cand;

  // Priority scan from rr_ptr; the SENS_LOG-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    index = {SENS_LOG{1'b0}};
    cand  = {SENS_LOG{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cand = rr_ptr + SENS_LOG'(i);
      if (!found && slot_full[cand]) begin
        found = 1'b1;
        index = cand;
      end else begin
        found = found;
        index = index;
      end
    end
  end

endmodule

// File: rtl/packet_reader.sv
// ---------------------------------------------------------------------------
// packet_reader
// Read-side master for the packet RAM. Picks complete slots round-robin,
// streams a header byte (slot id) plus 2**PKT_LOG payload bytes over a
// valid/ready byte stream, then pulses slot_release for that slot.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   slot_full      per-slot "packet complete" level from the writer
//   slot_release   one-cycle one-hot pulse when a slot has been fully sent
//   read_addr      RAM read address {slot, byte_idx}, valid with rd_en
//   rd_en          RAM read enable (high only while streaming payload)
//   rd_data        RAM read data, combinational from read_addr
//   tx_data        stream byte (registered)
//   tx_valid       tx_data valid (registered)
//   tx_ready       downstream accept
//   tx_first       header byte qualifier (registered)
//   tx_last        final payload byte qualifier (registered)
//   busy           FSM is not idle
// ---------------------------------------------------------------------------
module packet_reader
  import packet_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int SENS_LOG   = SENS_LOG_DEF,
  parameter  int PKT_LOG    = PKT_LOG_DEF,
  localparam int ADDR_WIDTH = SENS_LOG + PKT_LOG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [(1<<SENS_LOG)-1:0] slot_full,
  output logic [(1<<SENS_LOG)-1:0] slot_release,
  output logic [ADDR_WIDTH-1:0]    read_addr,
  output logic                     rd_en,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_first,
  output logic                     tx_last,
  output logic                     busy
);

  localparam int NUM_SLOTS = 1 << SENS_LOG;
  localparam logic [PKT_LOG:0]     LAST_IDX  = {1'b0, {PKT_LOG{1'b1}}};
  localparam logic [PKT_LOG:0]     BYTE_ONE  = {{PKT_LOG{1'b0}}, 1'b1};
  localparam logic [SENS_LOG-1:0]  SLOT_ONE  = {{(SENS_LOG-1){1'b0}}, 1'b1};
  localparam logic [NUM_SLOTS-1:0] ONEHOT_0  = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_t              state;
  logic [SENS_LOG-1:0] rr_ptr;
  logic [SENS_LOG-1:0] cur_slot;
  // One bit wider than the payload index so the terminal count is explicit.
  logic [PKT_LOG:0]    byte_idx;
  logic                arb_found;
  logic [SENS_LOG-1:0] arb_index;
  logic                out_free;

  packet_reader_rr_arbiter #(
    .SENS_LOG (SENS_LOG)
  ) u_arb (
    .slot_full (slot_full),
    .rr_ptr    (rr_ptr),
    .found     (arb_found),
    .index     (arb_index)
  );

  // Output register can take a new byte when empty or drained this cycle.
  assign out_free = !tx_valid || tx_ready;
  assign busy     = (state != ST_IDLE);

  // RAM read port is driven only while streaming payload; a stall holds
  // byte_idx, so the address stays frozen too.
  always_comb begin
    rd_en     = 1'b0;
    read_addr = {ADDR_WIDTH{1'b0}};
    if (state == ST_DATA) begin
      rd_en     = 1'b1;
      read_addr = ADDR_WIDTH'(slot_addr(16'(cur_slot), 16'(byte_idx), unsigned'(PKT_LOG)));
    end else begin
      rd_en     = 1'b0;
      read_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  // Reader FSM with the one-entry output register and release pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= {SENS_LOG{1'b0}};
      cur_slot     <= {SENS_LOG{1'b0}};
      byte_idx     <= {(PKT_LOG+1){1'b0}};
      tx_data      <= {DATA_WIDTH{1'b0}};
      tx_valid     <= 1'b0;
      tx_first     <= 1'b0;
      tx_last      <= 1'b0;
      slot_release <= {NUM_SLOTS{1'b0}};
    end else begin
      slot_release <= {NUM_SLOTS{1'b0}};
      // Drain on handshake; a load below in the same cycle takes precedence.
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
        tx_first <= 1'b0;
        tx_last  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            cur_slot <= arb_index;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_free) begin
            tx_data  <= DATA_WIDTH'(cur_slot);
            tx_first <= 1'b1;
            tx_last  <= 1'b0;
            tx_valid <= 1'b1;
            byte_idx <= {(PKT_LOG+1){1'b0}};
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (out_free) begin
            tx_data  <= rd_data;
            tx_first <= 1'b0;
            tx_last  <= (byte_idx == LAST_IDX);
            tx_valid <= 1'b1;
            byte_idx <= byte_idx + BYTE_ONE;
            if (byte_idx == LAST_IDX) begin
              state <= ST_REL;
            end
          end
        end
        ST_REL: begin
          // Release only once the final byte has actually left.
          if (tx_valid && tx_ready && tx_last) begin
            slot_release <= ONEHOT_0 << cur_slot;
            rr_ptr       <= cur_slot + SLOT_ONE;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
